// File: rtl/poly_mod_addsub_pipe.sv
// poly_mod_addsub_pipe: streaming multi-lane modular add/sub/rsub/reduce
// for Kyber coefficients (q = 3329), 3-stage pipeline, valid/ready stall.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready = advance enable)
//   mode                op select, sampled on beat 0 of a polynomial
//   a, b                LANES packed WIDTH-bit operands
//   out_valid/out_ready output beat handshake
//   o                   LANES packed results in [0, Q-1]
//   out_last            marks the output of the final beat of a polynomial
module poly_mod_addsub_pipe #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329,
    parameter int LANES = 1,
    parameter int N     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] o,
    output logic                   out_last
);

    localparam int W2    = WIDTH + 2;
    localparam int BEATS = N / LANES;
    localparam int CW    = $clog2(BEATS);
    localparam int DW    = LANES * W2;

    localparam logic [W2-1:0] QW      = W2'(Q);
    localparam logic [W2-1:0] Q2      = W2'(2 * Q);
    localparam logic [CW-1:0] CNT_MAX = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef struct packed {
        logic          valid;
        logic          last;
        logic [DW-1:0] data;
    } stage_t;

    function automatic logic [W2-1:0] csub(input logic [W2-1:0] t);
        return (t >= QW) ? t - QW : t;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    op_e           mode_q, mode_d;
    stage_t        s1_q, s1_d;
    stage_t        s2_q, s2_d;
    stage_t        s3_q, s3_d;

    logic          adv;
    logic          accept;
    logic          first;
    op_e           op;
    logic [W2-1:0] ea, eb, t;

    always_comb begin
        adv    = !s3_q.valid || out_ready;
        accept = in_valid && adv;
        first  = (cnt_q == '0);
        op     = first ? op_e'(mode) : mode_q;

        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (accept) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            if (first) begin
                mode_d = op_e'(mode);
            end
        end

        s1_d.valid = accept;
        s1_d.last  = accept && (cnt_q == CNT_MAX);
        s1_d.data  = '0;
        ea = '0;
        eb = '0;
        t  = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = {2'b00, a[i*WIDTH +: WIDTH]};
            eb = {2'b00, b[i*WIDTH +: WIDTH]};
            // 2Q bias keeps the differences non-negative for any raw input
            unique case (op)
                OP_ADD:  t = ea + eb;
                OP_SUB:  t = ea + Q2 - eb;
                OP_RSUB: t = eb + Q2 - ea;
                OP_PASS: t = ea;
            endcase
            s1_d.data[i*W2 +: W2] = t;
        end

        s2_d.valid = s1_q.valid;
        s2_d.last  = s1_q.last;
        s3_d.valid = s2_q.valid;
        s3_d.last  = s2_q.last;
        s2_d.data  = '0;
        s3_d.data  = '0;
        o          = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_d.data[i*W2 +: W2] = csub(s1_q.data[i*W2 +: W2]);
            s3_d.data[i*W2 +: W2] = csub(s2_q.data[i*W2 +: W2]);
            // third reduction is combinational; result is < Q so fits WIDTH
            o[i*WIDTH +: WIDTH] = WIDTH'(csub(s3_q.data[i*W2 +: W2]));
        end

        in_ready  = adv;
        out_valid = s3_q.valid;
        out_last  = s3_q.last && s3_q.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= OP_ADD;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            // whole-pipeline stall: every stage holds together
            if (adv) begin
                s1_q <= s1_d;
                s2_q <= s2_d;
                s3_q <= s3_d;
            end
        end
    end

endmodule

// File: tb/tb_poly_mod_addsub_pipe.sv
// tb_poly_mod_addsub_pipe: directed + random stimulus against a
// plain-arithmetic reference model with an in-order expected queue.
module tb_poly_mod_addsub_pipe;

    localparam int W     = 12;
    localparam int QM    = 3329;
    localparam int L     = 2;
    localparam int NC    = 8;
    localparam int BEATS = NC / L;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     mode;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] o;
    logic           out_last;

    always #5 clk = ~clk;

    poly_mod_addsub_pipe #(
        .WIDTH(W),
        .Q    (QM),
        .LANES(L),
        .N    (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o        (o),
        .out_last (out_last)
    );

    typedef struct {
        logic [L*W-1:0] o;
        logic           last;
        int             t;
        int             g0;
    } exp_t;

    exp_t           q[$];
    int             n_assert = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    int             mcnt     = 0;
    logic [1:0]     mmode    = 2'b00;
    int             gold0    = -1;
    bit             stalled_prev = 0;
    bit             chk_rst  = 0;
    bit             lat_chk  = 0;
    bit             rnd_ready = 0;
    bit             accepted = 0;
    logic [L*W-1:0] prev_o;
    logic           prev_last;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] m,
                                            input int x, input int y);
        int r;
        case (m)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = y - x;
            default: r = x;
        endcase
        r = r % QM;
        if (r < 0) r = r + QM;
        return W'(r);
    endfunction

    function automatic logic [L*W-1:0] pk(input int x0, input int x1);
        return {W'(x1), W'(x0)};
    endfunction

    function automatic int rv();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
                0:       return 0;
                1:       return 4095;
                2:       return QM - 1;
                default: return QM;
            endcase
        end
        return int'($urandom_range(0, 4095));
    endfunction

    task automatic step();
        exp_t       e;
        logic [1:0] em;
        @(negedge clk);
        if (!rst) begin
            if (chk_rst) begin
                chk("rst_out_valid", 32'(out_valid), 32'(0));
                chk("rst_out_last", 32'(out_last), 32'(0));
                chk("rst_o", 32'(o), 32'(0));
                chk("rst_in_ready", 32'(in_ready), 32'(1));
                chk_rst = 0;
            end
            chk("in_ready_rule", 32'(in_ready),
                32'(!out_valid || out_ready));
            if (stalled_prev) begin
                chk("stall_valid", 32'(out_valid), 32'(1));
                chk("stall_o", 32'(o), 32'(prev_o));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'(0));
                end else if (out_ready) begin
                    e = q.pop_front();
                    chk("o", 32'(o), 32'(e.o));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    for (int i = 0; i < L; i++)
                        chk("o_lt_q", 32'(o[i*W +: W] < W'(QM)), 32'(1));
                    if (e.g0 >= 0)
                        chk("golden_lane0", 32'(o[W-1:0]), 32'(e.g0));
                    if (lat_chk)
                        chk("latency", 32'(cyc - e.t), 32'(3));
                end
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            prev_o       = o;
            prev_last    = out_last;
            accepted     = 0;
            if (in_valid && in_ready) begin
                em = (mcnt == 0) ? mode : mmode;
                if (mcnt == 0) mmode = mode;
                for (int i = 0; i < L; i++)
                    e.o[i*W +: W] = ref_op(em, int'(a[i*W +: W]),
                                           int'(b[i*W +: W]));
                e.last = (mcnt == BEATS - 1);
                e.t    = cyc;
                e.g0   = gold0;
                mcnt   = (mcnt + 1) % BEATS;
                q.push_back(e);
                accepted = 1;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            mcnt         = 0;
            mmode        = 2'b00;
            stalled_prev = 0;
        end
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [1:0] m, input logic [L*W-1:0] av,
                        input logic [L*W-1:0] bv, input int g);
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        gold0    = g;
        for (int k = 0; k < 64; k++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 32'(accepted), 32'(1));
        gold0    = -1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 2'b00;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        step();
        step();
        rst     = 1'b0;
        chk_rst = 1;
        step();

        lat_chk = 1;
        send(2'd1, pk(0, rv()), pk(4095, rv()), 2563);
        send(2'd3, pk(4095, rv()), pk(0, rv()), 766);
        send(2'd0, pk(5, rv()), pk(5, rv()), 0);
        send(2'd2, pk(rv(), rv()), pk(rv(), rv()), -1);

        send(2'd0, pk(4095, rv()), pk(4095, rv()), 1532);
        for (int k = 0; k < 3; k++)
            send(2'd1, pk(rv(), rv()), pk(rv(), rv()), -1);

        send(2'd2, pk(1, rv()), pk(0, rv()), 3328);
        send(2'd0, pk(rv(), rv()), pk(rv(), rv()), -1);
        idle(3);
        send(2'd3, pk(rv(), rv()), pk(rv(), rv()), -1);
        send(2'd1, pk(rv(), rv()), pk(rv(), rv()), -1);

        send(2'd3, pk(3329, rv()), pk(rv(), rv()), 0);
        send(2'd0, pk(4095, rv()), pk(rv(), rv()), 766);
        send(2'd1, pk(rv(), rv()), pk(rv(), rv()), -1);
        send(2'd2, pk(rv(), rv()), pk(rv(), rv()), -1);

        send(2'd1, pk(10, rv()), pk(20, rv()), 3319);
        for (int k = 0; k < 3; k++)
            send(2'd0, pk(rv(), rv()), pk(rv(), rv()), -1);
        send(2'd0, pk(10, rv()), pk(20, rv()), 30);
        idle(5);

        lat_chk   = 0;
        rnd_ready = 1;
        for (int k = 0; k < 400; k++)
            send(2'($urandom_range(0, 3)), pk(rv(), rv()), pk(rv(), rv()), -1);
        rnd_ready = 0;
        out_ready = 1'b1;
        idle(6);
        chk("drain_empty", 32'(q.size()), 32'(0));

        lat_chk = 1;
        while (mcnt != 0)
            send(2'd0, pk(rv(), rv()), pk(rv(), rv()), -1);
        send(2'd1, pk(rv(), rv()), pk(rv(), rv()), -1);
        send(2'd1, pk(rv(), rv()), pk(rv(), rv()), -1);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = pk(rv(), rv());
        b        = pk(rv(), rv());
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_rst  = 1;
        step();
        send(2'd2, pk(0, rv()), pk(7, rv()), 7);
        for (int k = 0; k < BEATS - 1; k++)
            send(2'd0, pk(rv(), rv()), pk(rv(), rv()), -1);
        idle(5);

        for (int k = 0; k < 1500; k++) begin
            if (mcnt == 0)
                send(((k / BEATS) % 2 == 0) ? 2'd1 : 2'd0,
                     pk(rv(), rv()), pk(rv(), rv()), -1);
            else
                send(2'($urandom_range(0, 3)), pk(rv(), rv()),
                     pk(rv(), rv()), -1);
        end
        idle(5);
        chk("final_empty", 32'(q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
